// File: rtl/decoder_pkg.sv
// Shared types and the decode function for the one-hot/thermometer decoder pipe.
// decode_lines is also the reference model the bench may reuse.
package decoder_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Widest word the function produces; callers size-cast down to their line count.
   localparam int DEC_MAX_LINES = 64;

   function automatic logic [DEC_MAX_LINES-1:0] decode_lines(input int unsigned idx,
                                                              input logic        mode);
      logic [DEC_MAX_LINES-1:0] lines;
      lines = {DEC_MAX_LINES{1'b0}};
      for (int unsigned i = 0; i < DEC_MAX_LINES; i++) begin
         lines[i] = mode ? (i <= idx) : (i == idx);
      end
      return lines;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;

   // Counter register: clear first, then increment unless already at the ceiling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (inc && (cnt_r != {W{1'b1}})) begin
         cnt_r <= cnt_r + W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Flow-controlled index-to-line decoder with a two-entry skid buffer and
// per-line saturating hit counters. Decode happens as a code enters the buffer.
module onehot_decoder_pipe
   import decoder_pkg::*;
#(
   parameter int IDX_W = 2,
   parameter int CNT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IDX_W-1:0]            in_idx,
   input  logic                        in_mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [(2**IDX_W)-1:0]       out_lines,
   output logic [IDX_W-1:0]            out_idx,
   input  logic                        clr_cnt,
   output logic [(2**IDX_W)*CNT_W-1:0] hit_cnt
);

   localparam int LINES = 2**IDX_W;

   occ_e             occ_r;
   occ_e             occ_next_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [LINES-1:0] out_lines_r;
   logic [IDX_W-1:0] out_idx_r;
   logic [LINES-1:0] skid_lines_r;
   logic [IDX_W-1:0] skid_idx_r;

   logic             accept_s;
   logic             drain_s;
   logic             load_out_s;
   logic             load_skid_s;
   logic             skid_to_out_s;
   logic [LINES-1:0] in_lines_s;
   logic [LINES-1:0] inc_s;

   assign accept_s   = in_valid && in_ready_r;
   assign drain_s    = out_valid_r && out_ready;
   assign in_lines_s = LINES'(decode_lines(32'(in_idx), in_mode));

   // Occupancy next state and data-path steering.
   always_comb begin
      occ_next_s    = occ_r;
      load_out_s    = 1'b0;
      load_skid_s   = 1'b0;
      skid_to_out_s = 1'b0;
      case (occ_r)
         OCC_EMPTY: begin
            if (accept_s) begin
               occ_next_s = OCC_ONE;
               load_out_s = 1'b1;
            end else begin
               occ_next_s = OCC_EMPTY;
            end
         end
         OCC_ONE: begin
            if (accept_s && drain_s) begin
               occ_next_s = OCC_ONE;
               load_out_s = 1'b1;
            end else if (accept_s) begin
               occ_next_s  = OCC_FULL;
               load_skid_s = 1'b1;
            end else if (drain_s) begin
               occ_next_s = OCC_EMPTY;
            end else begin
               occ_next_s = OCC_ONE;
            end
         end
         OCC_FULL: begin
            if (drain_s) begin
               occ_next_s    = OCC_ONE;
               skid_to_out_s = 1'b1;
            end else begin
               occ_next_s = OCC_FULL;
            end
         end
         default: begin
            occ_next_s = OCC_EMPTY;
         end
      endcase
   end

   // State and handshake flags, registered from the next state so in_ready never sees out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r       <= OCC_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         occ_r       <= occ_next_s;
         in_ready_r  <= (occ_next_s != OCC_FULL);
         out_valid_r <= (occ_next_s != OCC_EMPTY);
      end
   end

   // Output and skid entries; the output word holds whenever nothing is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_lines_r  <= {LINES{1'b0}};
         out_idx_r    <= {IDX_W{1'b0}};
         skid_lines_r <= {LINES{1'b0}};
         skid_idx_r   <= {IDX_W{1'b0}};
      end else begin
         if (load_out_s) begin
            out_lines_r <= in_lines_s;
            out_idx_r   <= in_idx;
         end else if (skid_to_out_s) begin
            out_lines_r <= skid_lines_r;
            out_idx_r   <= skid_idx_r;
         end else begin
            out_lines_r <= out_lines_r;
            out_idx_r   <= out_idx_r;
         end
         if (load_skid_s) begin
            skid_lines_r <= in_lines_s;
            skid_idx_r   <= in_idx;
         end else begin
            skid_lines_r <= skid_lines_r;
            skid_idx_r   <= skid_idx_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_lines = out_lines_r;
   assign out_idx   = out_idx_r;

   // Only the index line counts, so thermometer words bump a single counter.
   for (genvar g = 0; g < LINES; g++) begin : g_cnt
      assign inc_s[g] = drain_s && (out_idx_r == IDX_W'(g));

      sat_counter #(
         .W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc_s[g]),
         .clr   (clr_cnt),
         .cnt   (hit_cnt[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed self-checking bench for onehot_decoder_pipe (IDX_W=2, CNT_W=2).
`timescale 1ns/1ps
module tb_onehot_decoder_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_idx;
   logic       in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_lines;
   logic [1:0] out_idx;
   logic       clr_cnt;
   logic [7:0] hit_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   onehot_decoder_pipe #(.IDX_W(2), .CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lines (out_lines),
      .out_idx   (out_idx),
      .clr_cnt   (clr_cnt),
      .hit_cnt   (hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] stream_exp [4];

   initial begin
      stream_exp[0] = 4'b1000;
      stream_exp[1] = 4'b0100;
      stream_exp[2] = 4'b0010;
      stream_exp[3] = 4'b0001;

      // Reset held with a code on the input.
      rst_n = 1'b0; in_valid = 1'b1; in_idx = 2'd2; in_mode = 1'b0;
      out_ready = 1'b1; clr_cnt = 1'b0;
      repeat (3) step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_lines", 64'(out_lines), 64'd0);
      check("rst_out_idx",   64'(out_idx),   64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_hit_cnt",   64'(hit_cnt),   64'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) step();
      check("no_phantom", 64'(out_valid), 64'd0);

      // Streaming one-hot, one code per cycle.
      in_valid = 1'b1; in_mode = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_idx = 2'(3 - k);
         step();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_lines", 64'(out_lines), 64'(stream_exp[k]));
         check("stream_idx",   64'(out_idx),   64'(3 - k));
         check("stream_ready", 64'(in_ready),  64'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", 64'(out_valid), 64'd0);
      check("stream_hits",    64'(hit_cnt),   64'h55);

      // Thermometer idx 2: only line 2 counts.
      in_valid = 1'b1; in_idx = 2'd2; in_mode = 1'b1;
      step();
      check("thermo_lines", 64'(out_lines), 64'b0111);
      check("thermo_idx",   64'(out_idx),   64'd2);
      in_valid = 1'b0; in_mode = 1'b0;
      step();
      check("thermo_hits", 64'(hit_cnt), 64'h65);

      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      check("clear_hits", 64'(hit_cnt), 64'd0);

      // Backpressure: two codes fill the buffer.
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 2'd1;
      step();
      check("bp_first_ready", 64'(in_ready),  64'd1);
      check("bp_first_lines", 64'(out_lines), 64'b0010);
      in_idx = 2'd3;
      step();
      check("bp_full_ready", 64'(in_ready),  64'd0);
      check("bp_full_lines", 64'(out_lines), 64'b0010);
      in_valid = 1'b0;
      step();
      check("bp_hold_lines", 64'(out_lines), 64'b0010);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_hits",  64'(hit_cnt),   64'd0);
      out_ready = 1'b1;
      step();
      check("bp_drain2_lines", 64'(out_lines), 64'b1000);
      check("bp_drain2_idx",   64'(out_idx),   64'd3);
      check("bp_ready_back",   64'(in_ready),  64'd1);
      step();
      check("bp_empty",  64'(out_valid), 64'd0);
      check("bp_hits",   64'(hit_cnt),   64'h44);

      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;

      // Saturation: five drains of idx 0 stop at 3.
      in_valid = 1'b1; in_idx = 2'd0;
      repeat (5) step();
      in_valid = 1'b0;
      step();
      check("sat_hits", 64'(hit_cnt), 64'h03);

      // Clear coinciding with a drain of idx 0 loses that increment.
      in_valid = 1'b1; in_idx = 2'd0;
      step();
      in_valid = 1'b0; clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      check("clr_drain_hits", 64'(hit_cnt), 64'd0);
      step();
      check("clr_drain_after", 64'(hit_cnt),   64'd0);
      check("clr_drain_valid", 64'(out_valid), 64'd0);

      // Reset mid-operation discards a full buffer.
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 2'd2;
      step();
      in_idx = 2'd1;
      step();
      in_valid = 1'b0;
      check("mid_full_ready", 64'(in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready),  64'd1);
      check("mid_rst_lines", 64'(out_lines), 64'd0);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      step();
      check("mid_rst_no_output", 64'(out_valid), 64'd0);
      check("mid_rst_hits",      64'(hit_cnt),   64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
